// File: rtl/banner_pkg.sv
// ---- banner_pkg : shared state type, grid size and message bitmaps (rev 1.0) ----
`default_nettype none

package banner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_HOLD   = 2'd2
  } banner_state_t;

  localparam int GRID_W = 32;
  localparam int GRID_H = 25;

  // One 32-bit word per cell row; bit 31 is cell column 0 so the literals read left to right.
  localparam logic [31:0] MSG_YOU_WIN [0:24] = '{
    32'b10001_0_01110_0_10001_000_000_000_000_000,
    32'b10001_0_10001_0_10001_000_000_000_000_000,
    32'b01010_0_10001_0_10001_000_000_000_000_000,
    32'b00100_0_10001_0_10001_000_000_000_000_000,
    32'b00100_0_10001_0_10001_000_000_000_000_000,
    32'b00100_0_10001_0_10001_000_000_000_000_000,
    32'b00100_0_01110_0_01110_000_000_000_000_000,
    32'h0000_0000,
    32'h0000_0000,
    32'b000000_10001_0_01110_0_10001_000_000_000,
    32'b000000_10001_0_00100_0_11001_000_000_000,
    32'b000000_10001_0_00100_0_10101_000_000_000,
    32'b000000_10101_0_00100_0_10011_000_000_000,
    32'b000000_10101_0_00100_0_10001_000_000_000,
    32'b000000_10101_0_00100_0_10001_000_000_000,
    32'b000000_01010_0_01110_0_10001_000_000_000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'hFFFF_FFFF
  };

  localparam logic [31:0] MSG_GAME_OVER [0:24] = '{
    32'b01110_0_01110_0_10001_0_11111_000_000_000,
    32'b10001_0_10001_0_11011_0_10000_000_000_000,
    32'b10000_0_10001_0_10101_0_10000_000_000_000,
    32'b10111_0_11111_0_10101_0_11110_000_000_000,
    32'b10001_0_10001_0_10001_0_10000_000_000_000,
    32'b10001_0_10001_0_10001_0_10000_000_000_000,
    32'b01110_0_10001_0_10001_0_11111_000_000_000,
    32'h0000_0000,
    32'h0000_0000,
    32'b01110_0_10001_0_11111_0_11110_000_000_000,
    32'b10001_0_10001_0_10000_0_10001_000_000_000,
    32'b10001_0_10001_0_10000_0_10001_000_000_000,
    32'b10001_0_10001_0_11110_0_11110_000_000_000,
    32'b10001_0_10001_0_10000_0_10100_000_000_000,
    32'b10001_0_01010_0_10000_0_10010_000_000_000,
    32'b01110_0_00100_0_11111_0_10001_000_000_000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'hFFFF_FFFF
  };

endpackage

`default_nettype wire

// File: rtl/banner_glyph_rom.sv
// ---- banner_glyph_rom : combinational cell lookup into the message bitmaps (rev 1.0) ----
`default_nettype none

module banner_glyph_rom
  import banner_pkg::*;
(
  input  logic       msg,
  input  logic [4:0] cell_r,
  input  logic [4:0] cell_c,
  output logic       lit_bit
);

  // ~cell_c maps cell column 0 onto bit 31 of the row word.
  always_comb begin
    lit_bit = 1'b0;
    if (cell_r < 5'(GRID_H)) begin
      if (msg) begin
        lit_bit = MSG_GAME_OVER[cell_r][~cell_c];
      end else begin
        lit_bit = MSG_YOU_WIN[cell_r][~cell_c];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/banner_scroller.sv
// ---- banner_scroller : scrolls a bitmap banner up the screen, parks and blinks it (rev 1.0) ----
`default_nettype none

module banner_scroller
  import banner_pkg::*;
#(
  parameter int                 PIX_W       = 12,
  parameter int                 COLOR_W     = 4,
  parameter logic [COLOR_W-1:0] FG          = {COLOR_W{1'b1}},
  parameter int                 TICK_DIV    = 1000000,
  parameter int                 STEP        = 3,
  parameter int                 START_ROW   = 480,
  parameter int                 START_COL   = 192,
  parameter int                 STOP_ROW    = 140,
  parameter int                 SCALE_LOG2  = 3,
  parameter int                 BLINK_TICKS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pixel_row,
  input  logic [PIX_W-1:0]   pixel_column,
  input  logic               enable,
  input  logic               msg_sel,
  input  logic               blink_en,
  output logic [COLOR_W-1:0] pix_out,
  output logic               pix_hit,
  output logic               parked
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [TW-1:0]    TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [PIX_W-1:0] START_POS  = PIX_W'(START_ROW);
  localparam logic [PIX_W-1:0] STOP_POS   = PIX_W'(STOP_ROW);
  localparam logic [PIX_W-1:0] COL_POS    = PIX_W'(START_COL);
  localparam logic [PIX_W-1:0] STEP_V     = PIX_W'(STEP);
  localparam logic [PIX_W:0]   SCROLL_MIN = (PIX_W+1)'(STOP_ROW + STEP + 1);
  localparam logic [PIX_W:0]   ROW_SPAN   = (PIX_W+1)'(GRID_H << SCALE_LOG2);
  localparam logic [PIX_W:0]   COL_SPAN   = (PIX_W+1)'(GRID_W << SCALE_LOG2);

  logic [TW-1:0]    tick_cnt;
  logic             tick;

  banner_state_t    state, state_d;
  logic [PIX_W-1:0] row_pos, row_d;
  logic             vis, vis_d;
  logic [BW-1:0]    blink_cnt, blink_d;
  logic             msg_q, msg_d;

  logic [PIX_W:0]   dr, dc;
  logic [4:0]       cell_r, cell_c;
  logic             in_box;
  logic             rom_bit;
  logic             visible;
  logic             lit;

  // Motion timebase; runs regardless of state so ticks stay evenly spaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      row_pos   <= START_POS;
      vis       <= 1'b1;
      blink_cnt <= '0;
      msg_q     <= 1'b0;
    end else begin
      state     <= state_d;
      row_pos   <= row_d;
      vis       <= vis_d;
      blink_cnt <= blink_d;
      msg_q     <= msg_d;
    end
  end

  always_comb begin
    state_d = state;
    row_d   = row_pos;
    vis_d   = vis;
    blink_d = blink_cnt;
    msg_d   = msg_q;
    if (!enable) begin
      // Dropping enable rearms everything and takes priority over a tick.
      state_d = ST_IDLE;
      row_d   = START_POS;
      vis_d   = 1'b1;
      blink_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          msg_d   = msg_sel;
          row_d   = START_POS;
          state_d = ST_SCROLL;
        end
        ST_SCROLL: begin
          if (tick) begin
            if ({1'b0, row_pos} >= SCROLL_MIN) begin
              row_d = row_pos - STEP_V;
            end else begin
              row_d   = STOP_POS;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!blink_en) begin
            vis_d   = 1'b1;
            blink_d = '0;
          end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
              vis_d   = ~vis;
              blink_d = '0;
            end else begin
              blink_d = blink_cnt + BW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          row_d   = START_POS;
        end
      endcase
    end
  end

  // One extra bit keeps the offsets signed so pixels above/left of the banner test negative.
  assign dr     = {1'b0, pixel_row}    - {1'b0, row_pos};
  assign dc     = {1'b0, pixel_column} - {1'b0, COL_POS};
  assign in_box = !dr[PIX_W] && (dr < ROW_SPAN) && !dc[PIX_W] && (dc < COL_SPAN);
  assign cell_r = 5'(dr >> SCALE_LOG2);
  assign cell_c = 5'(dc >> SCALE_LOG2);

  banner_glyph_rom u_rom (
    .msg     (msg_q),
    .cell_r  (cell_r),
    .cell_c  (cell_c),
    .lit_bit (rom_bit)
  );

  assign visible = (state == ST_SCROLL) || ((state == ST_HOLD) && vis);
  assign lit     = visible && in_box && rom_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out <= '0;
      pix_hit <= 1'b0;
      parked  <= 1'b0;
    end else begin
      pix_out <= lit ? FG : '0;
      pix_hit <= lit;
      parked  <= (state == ST_HOLD);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_banner_scroller.sv
// ---- tb_banner_scroller : randomized check of banner_scroller against a behavioural model (rev 1.0) ----
`default_nettype none

module tb_banner_scroller;
  import banner_pkg::*;

  localparam int TD    = 4;
  localparam int STEP  = 3;
  localparam int START = 480;
  localparam int COL0  = 192;
  localparam int STOP  = 140;
  localparam int SL    = 3;
  localparam int S     = 1 << SL;
  localparam int BT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] prow, pcol;
  logic        enable, msg_sel, blink_en;
  logic [3:0]  pix_out;
  logic        pix_hit, parked;

  always #5 clk = ~clk;

  banner_scroller #(
    .PIX_W(12), .COLOR_W(4), .FG(4'hF), .TICK_DIV(TD), .STEP(STEP),
    .START_ROW(START), .START_COL(COL0), .STOP_ROW(STOP),
    .SCALE_LOG2(SL), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk), .rst(rst), .pixel_row(prow), .pixel_column(pcol),
    .enable(enable), .msg_sel(msg_sel), .blink_en(blink_en),
    .pix_out(pix_out), .pix_hit(pix_hit), .parked(parked)
  );

  // Model: mode 0 idle, 1 scrolling, 2 parked. Position is derived from tick count.
  int m_mode, m_n, m_ht, m_k, m_msg;
  bit e_hit, e_parked;
  bit chk_en;
  int total = 0, bad = 0;

  // Literal-expectation requests, consumed by the compare process.
  int    l_req = 0, l_seen = 0, l_which, l_exp;
  string l_name;

  function automatic int m_pos();
    if (m_mode == 0) return START;
    if (m_mode == 1) return START - STEP * m_n;
    return STOP;
  endfunction

  function automatic bit rom_lookup(int msg, int cr, int cc);
    logic [31:0] row;
    row = (msg != 0) ? MSG_GAME_OVER[cr] : MSG_YOU_WIN[cr];
    return row[31 - cc];
  endfunction

  function automatic bit m_lit(int r, int c);
    bit vis;
    int dr, dc;
    vis = (m_mode == 1) || (m_mode == 2 && ((m_ht / BT) % 2) == 0);
    dr  = r - m_pos();
    dc  = c - COL0;
    if (!vis || dr < 0 || dr >= GRID_H * S || dc < 0 || dc >= GRID_W * S) return 1'b0;
    return rom_lookup(m_msg, dr / S, dc / S);
  endfunction

  task automatic step_model();
    bit tk;
    if (rst) begin
      e_hit = 0; e_parked = 0;
      m_mode = 0; m_n = 0; m_ht = 0; m_msg = 0; m_k = 0;
    end else begin
      tk = (m_k % TD) == TD - 1;
      m_k++;
      e_hit    = m_lit(int'(prow), int'(pcol));
      e_parked = (m_mode == 2);
      if (!enable) begin
        m_mode = 0; m_n = 0; m_ht = 0;
      end else if (m_mode == 0) begin
        m_msg = int'(msg_sel); m_mode = 1; m_n = 0;
      end else if (m_mode == 1) begin
        if (tk) begin
          m_n++;
          if (START - STEP * m_n <= STOP) begin
            m_mode = 2; m_ht = 0;
          end
        end
      end else begin
        if (!blink_en) m_ht = 0;
        else if (tk) m_ht++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every edge against the model, plus any pending literal request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        chk("pix_hit", 32'(pix_hit), 32'(e_hit));
        chk("pix_out", 32'(pix_out), e_hit ? 32'hF : 32'h0);
        chk("parked", 32'(parked), 32'(e_parked));
        if (l_req != l_seen) begin
          l_seen = l_req;
          case (l_which)
            0:       chk(l_name, 32'(pix_hit), 32'(l_exp));
            1:       chk(l_name, 32'(parked),  32'(l_exp));
            default: chk(l_name, 32'(pix_out), 32'(l_exp));
          endcase
        end
      end
    end
  end

  task automatic cyc(input int r, input int c);
    prow = 12'(r);
    pcol = 12'(c);
    step_model();
    @(negedge clk);
  endtask

  // Mostly probe near the banner so position errors show up as pixel mismatches.
  task automatic cyc_rand();
    int r, c;
    if ($urandom_range(0, 3) != 0) begin
      r = m_pos() - 4 + int'($urandom_range(0, 208));
      c = COL0 - 4 + int'($urandom_range(0, 264));
      if (r > 479) r = int'($urandom_range(0, 479));
    end else begin
      r = int'($urandom_range(0, 479));
      c = int'($urandom_range(0, 639));
    end
    cyc(r, c);
  endtask

  task automatic lit(input string name, input int which, input int exp, input int r, input int c);
    l_name  = name;
    l_which = which;
    l_exp   = exp;
    l_req++;
    cyc(r, c);
  endtask

  task automatic run_to_hold(input string name);
    for (int i = 0; i < 1000 && m_mode != 2; i++) begin
      if (i > 0) msg_sel = 1'($urandom);
      cyc_rand();
    end
    cyc_rand();
    cyc_rand();
    lit(name, 1, 1, 140, 192);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; msg_sel = 1'b0; blink_en = 1'b0;
    prow = '0; pcol = '0; chk_en = 1'b0;
    @(negedge clk);
    cyc(0, 0);
    chk_en = 1'b1;
    cyc(0, 0);
    cyc(0, 0);
    rst = 1'b0;

    // Idle: whole-screen sweep, nothing lit.
    for (int r = 0; r < 480; r += 16)
      for (int c = 0; c < 640; c += 16)
        cyc(r, c);
    lit("idle_hit", 0, 0, 140, 192);
    lit("idle_parked", 1, 0, 140, 192);

    // Scroll and park with YOU WIN; msg_sel wiggles after latching.
    enable = 1'b1; msg_sel = 1'b0; blink_en = 1'b0;
    run_to_hold("park_parked");
    lit("park_topleft", 0, 1, 140, 192);
    lit("park_fg", 2, 15, 140, 192);
    lit("park_col31", 0, 0, 140, 440);
    lit("park_lastcell", 0, 1, 339, 447);
    lit("below_grid", 0, 0, 340, 192);
    lit("left_of_grid", 0, 0, 140, 191);

    // Blink, then steady.
    blink_en = 1'b1;
    for (int i = 0; i < 48; i++) cyc(140, 192);
    blink_en = 1'b0;
    for (int i = 0; i < 4; i++) cyc(140, 192);
    lit("blink_off_steady", 0, 1, 140, 192);

    // Abort at row 300 coincident with a tick.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cyc_rand();
    enable = 1'b1; msg_sel = 1'b0;
    for (int i = 0; i < 1000 && !(m_mode == 1 && m_pos() == 300 && (m_k % TD) == TD - 1); i++)
      cyc_rand();
    enable = 1'b0;
    lit("abort_edge", 0, 1, 300, 192);
    lit("abort_idle", 0, 0, 300, 192);

    // Re-enable with GAME OVER.
    enable = 1'b1; msg_sel = 1'b1;
    cyc_rand();
    run_to_hold("over_parked");
    lit("over_cell01", 0, 1, 140, 200);
    lit("over_cell00", 0, 0, 140, 192);

    // Synchronous reset in HOLD with enable held high.
    rst = 1'b1;
    lit("rst_hit", 0, 0, 140, 200);
    rst = 1'b0;
    lit("rst_parked", 1, 0, 140, 200);
    for (int i = 0; i < 40; i++) cyc_rand();

    // Randomized control traffic.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (enable) enable = ($urandom_range(0, 599) != 0);
      else        enable = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
      msg_sel = 1'($urandom);
      cyc_rand();
    end
    rst = 1'b0;
    cyc_rand();
    cyc_rand();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/banner_scroller.md
# banner_scroller

Parametrised full-screen message banner for the Space Invaders VGA path. On `enable` it scrolls a selectable bitmap message (`YOU WIN` / `GAME OVER`) up the screen, parks it at a stop row, and optionally blinks it. It emits a per-pixel intensity and hit flag for the VGA colour mux. The bitmap is stored as a scaled cell grid, not hand-coded compare chains.

## Interface
- `PIX_W`, 12, pixel coordinate width
- `COLOR_W`, 4, output intensity width
- `FG`, 4'hF, intensity driven on lit pixels
- `TICK_DIV`, 1000000, clocks per motion tick (≥2)
- `STEP`, 3, rows moved per tick (≥1)
- `START_ROW`, 480, banner top row while idle
- `START_COL`, 192, banner left column (fixed)
- `STOP_ROW`, 140, final top row (< `START_ROW`)
- `SCALE_LOG2`, 3, cell size is 2**`SCALE_LOG2` px
- `BLINK_TICKS`, 16, ticks per blink half-period (≥1)

Ports:
- `clk` in 1: pixel clock
- `rst` in 1: reset, **synchronous, active-high**
- `pixel_row` in `PIX_W`: current scan row
- `pixel_column` in `PIX_W`: current scan column
- `enable` in 1: level; high shows the banner, low hides and rearms it
- `msg_sel` in 1: 0 = `YOU WIN`, 1 = `GAME OVER`; latched on leaving IDLE
- `blink_en` in 1: blink while parked; sampled every cycle
- `pix_out` out `COLOR_W`: `FG` on lit pixel, else 0
- `pix_hit` out 1: lit pixel flag
- `parked` out 1: high in HOLD

## Operation
- **Tick counter**
  - Free-running, width `$clog2(TICK_DIV)`.
  - Counts 0..`TICK_DIV`-1 then wraps.
  - `tick` is high in the cycle the count equals `TICK_DIV`-1.
  - Runs in all states.
- **FSM states:** IDLE, SCROLL, HOLD.
  - IDLE: `row_pos`=`START_ROW`, banner invisible. When `enable`=1: latch `msg_sel`, go to SCROLL on the next edge (no tick wait).
  - SCROLL: on `tick`, if `row_pos` ≥ `STOP_ROW`+`STEP`+1, then `row_pos` -= `STEP`. Otherwise `row_pos` = `STOP_ROW` and go to HOLD. Comparison is unsigned in `PIX_W`+1 bits, so there is no wrap-around.
  - HOLD: `row_pos` holds. `blink_cnt` counts ticks; after `BLINK_TICKS` ticks, `vis` toggles and `blink_cnt` clears. If `blink_en`=0, `vis` is forced to 1 and `blink_cnt` is held at 0.
  - `enable`=0 in any state: go to IDLE on the next edge, with `row_pos`=`START_ROW`, `vis`=1, `blink_cnt`=0. This beats a simultaneous tick.
- **Visibility:** the banner is visible in SCROLL, and in HOLD when `vis`=1. Never in IDLE.
- **Bitmap and hit test**
  - Grid is 32 cells wide × 25 cells tall; cell size S = 2**`SCALE_LOG2`.
  - With dr = `pixel_row`-`row_pos` and dc = `pixel_column`-`START_COL`, computed in `PIX_W`+1 bits: inside iff 0 ≤ dr < 25·S and 0 ≤ dc < 32·S.
  - Cell coordinates: `cell_r` = dr>>`SCALE_LOG2`, `cell_c` = dc>>`SCALE_LOG2`.
  - lit = visible & inside & rom(msg, `cell_r`, `cell_c`).
  - Pixels below the screen (row ≥ 480) are never scanned. No clipping logic is needed.

## Timing
- `pix_out`/`pix_hit` are registered: 1-cycle latency from `pixel_row`/`pixel_column`. The VGA top compensates with one pipeline stage.
- State, `row_pos`, and `vis` update on the `tick` edge. Pixel output reflects the new position from the following cycle.
- Reset values: state=IDLE, `row_pos`=`START_ROW`, tick count=0, `blink_cnt`=0, `vis`=1, latched msg=0, `pix_out`=0, `pix_hit`=0, `parked`=0.
- `rst` mid-scroll behaves exactly like reset, regardless of `enable`. Re-entry to SCROLL needs `enable`=1 in a cycle after `rst` falls.
- `parked` is a registered state decode: high the cycle after the HOLD transition edge.
- `msg_sel` changes after leaving IDLE are ignored until the next IDLE visit.

## Structure
- Package `banner_pkg`:
  - state enum `banner_state_t`
  - constants `GRID_W`=32, `GRID_H`=25
  - the two message bitmaps as `logic [31:0] [0:24]` constant arrays. Message 0 cell (0,0) is lit (top-left of `Y`); cell (0,31) is unlit.
- Sub-module `banner_glyph_rom`: combinational (msg, `cell_r`, `cell_c`) → bit, indexed from the package constants.
- Target size: about 200 lines for the top module plus ROM.

## Test plan
- **Reset/idle:** bench parameters `TICK_DIV`=4, `STEP`=3, `START_ROW`=480, `STOP_ROW`=140; `enable`=0. Sweep the whole screen → `pix_hit` never 1; `parked`=0; `row_pos`=480.
- **Scroll and park:** `enable`=1, `msg_sel`=0. `row_pos` decreases by 3 every 4 cycles (477, 474, …, 141). Then it clamps to 140, and `parked`=1 one cycle later. Pixel (140, 192) → `pix_hit`=1 one cycle after presentation; pixel (140, 440) → 0.
- **Blink:** parked, `blink_en`=1, `BLINK_TICKS`=2. `pix_hit` at (140, 192) alternates every 8 cycles. Setting `blink_en`=0 gives a steady 1 from the next cycle.
- **Mid-scroll abort:** at `row_pos`=300, drop `enable` coincident with a tick → next cycle IDLE, `row_pos`=480. Re-enable with `msg_sel`=1 → the `GAME OVER` bitmap is rendered.
- **Sync reset mid-HOLD:** assert `rst` for 1 cycle with `enable`=1 → all outputs at reset values the next cycle. The scroll restarts from 480 after `rst` is released.
- **Boundary cells:** parked at 140, S=8. Pixels (140+199, 192+255) and (140+200, 192) → the second gives `pix_hit`=0. Pixel column 191 → 0.
